multicycle_control: RTL and testbench
=====================================

# multicycle_control

Multicycle control unit for the processor datapath. Sequences each instruction through fetch, decode, execute, memory and writeback states. Drives the immediate-extender select (`imm_src`), register-file, memory, PC and ALU controls. Waits on a memory-ready handshake for every memory access. Sits beside the datapath and owns all of its strobe and select signals.

## Interface
Parameters:
- `OPW`, 4, opcode width (opcode is `Instr[31:28]`; `Instr[27:0]` feeds the extender)

Ports:
- `clk`  in  1  system clock
- `rst_n`  in  1  asynchronous, active-low reset
- `run`  in  1  leave IDLE and start fetching
- `opcode`  in  OPW  instruction opcode from the instruction register
- `zero`  in  1  ALU zero flag, valid in BRANCH
- `mem_ready`  in  1  memory has completed the current access
- `mem_req`  out  1  memory access request
- `mem_write`  out  1  store strobe, valid with `mem_req`
- `adr_src`  out  1  memory address select: 0 = PC, 1 = ALU result
- `ir_write`  out  1  load the instruction register
- `pc_write`  out  1  update the PC
- `reg_write`  out  1  register-file write
- `alu_src_b`  out  2  ALU B select: 00 = register, 01 = ExtImm, 10 = constant 4
- `alu_op`  out  2  ALU operation: 00 = add, 01 = sub, 10 = and, 11 = or
- `result_src`  out  1  writeback select: 0 = ALU, 1 = memory
- `imm_src`  out  2  extender select, registered
- `halted`  out  1  high in HALT
- `illegal_op`  out  1  one-cycle pulse on an undefined opcode

## Operation
- **States:** IDLE, FETCH, DECODE, EXECR, EXECI, ALUWB, MEMADR, MEMREAD, MEMWB, MEMWRITE, BRANCH, HALT.
- **Reset:** while `rst_n` is low the state is forced to IDLE and every output is 0 (`imm_src` = 00). Reset asserted mid-instruction abandons that instruction with no further strobes.
- **IDLE:** all outputs 0. Moves to FETCH when `run` = 1.
- **FETCH:**
  - Drives `mem_req` = 1 and `adr_src` = 0.
  - On `mem_ready` = 1: `ir_write` = 1, `pc_write` = 1, `alu_src_b` = 10, `alu_op` = 00 (PC + 4), then DECODE. Otherwise FETCH is held.
- **DECODE:** registers `imm_src` from the opcode. Next state by opcode:
  - 0000–0011 (ADD/SUB/AND/OR register): EXECR, `imm_src` = 11.
  - 0100/0101 (ADDI/SUBI): EXECI, `imm_src` = 10.
  - 0110/0111 (LDR/STR): MEMADR, `imm_src` = 01.
  - 1000/1001 (B/BEQ): BRANCH, `imm_src` = 00.
  - 1111: HALT.
  - Any other opcode: pulse `illegal_op`, return to FETCH, leave `imm_src` unchanged.
- **EXECR:** `alu_src_b` = 00, `alu_op` = opcode[1:0], then ALUWB.
- **EXECI:** `alu_src_b` = 01, `alu_op` = {1'b0, opcode[0]}, then ALUWB.
- **ALUWB:** `reg_write` = 1, `result_src` = 0, then FETCH.
- **MEMADR:** `alu_src_b` = 01, `alu_op` = 00. Goes to MEMREAD for opcode 0110, MEMWRITE for 0111.
- **MEMREAD:** `mem_req` = 1, `adr_src` = 1. Held until `mem_ready`, then MEMWB.
- **MEMWB:** `reg_write` = 1, `result_src` = 1, then FETCH.
- **MEMWRITE:** `mem_req` = 1, `mem_write` = 1, `adr_src` = 1. Held until `mem_ready`, then FETCH.
- **BRANCH:**
  - `alu_src_b` = 01, `alu_op` = 00.
  - `pc_write` = 1 for B; for BEQ only when `zero` = 1.
  - Then FETCH.
- **HALT:** `halted` = 1, all strobes 0. Left only by reset; `run` is ignored.
- Outputs not listed for a state are 0.

## Timing
- The state register is updated on the `clk` rising edge.
- Outputs are decoded combinationally from the current state. The exceptions are `imm_src`, which is registered in DECODE, and the FETCH strobes, which are gated by `mem_ready`.
- `imm_src` changes one cycle after DECODE and holds until the next DECODE, so the extender output is stable from EXECI/MEMADR/BRANCH onward.
- Minimum cycles per instruction, with `mem_ready` already high:

  | Instruction | Cycles |
  |---|---|
  | Register ALU | 4 |
  | Immediate ALU | 4 |
  | LDR | 5 |
  | STR | 4 |
  | B / BEQ | 3 |

  Each memory wait cycle adds 1.
- `mem_ready` is sampled only in FETCH, MEMREAD and MEMWRITE; elsewhere it is ignored.
- `mem_req` stays high continuously until the cycle in which `mem_ready` is seen.

## Structure
- Package `ctrl_pkg` holds:
  - the `state_t` enum;
  - opcode localparams;
  - `IMM_*` constants (00 = branch, 01 = memory, 10 = ALU-immediate, 11 = register);
  - `ALU_*` constants;
  - `ALUB_*` constants.
- Sub-module `control_decode`: combinational opcode → {instruction class, `imm_src`, legal}. It is used by DECODE.

## Test plan
- Reset while mid-LDR in MEMREAD, then release with `run` = 1 → all outputs 0 during reset; FETCH with `mem_req` = 1 one cycle after `run`.
- ADDI (0100) with `mem_ready` tied high → 4 cycles; `imm_src` = 10 from EXECI; `alu_src_b` = 01; `reg_write` pulse in cycle 4.
- LDR with `mem_ready` delayed 3 cycles in MEMREAD → `mem_req` and `adr_src` held high for 3 cycles; MEMWB `reg_write` = 1, `result_src` = 1; 8 cycles total.
- BEQ with `zero` = 0, then BEQ with `zero` = 1 → `pc_write` stays 0 in the first BRANCH and is 1 in the second; `imm_src` = 00 in both.
- Opcode 1010 → one-cycle `illegal_op` pulse, back to FETCH, `imm_src` keeps its previous value.
- Opcode 1111 → `halted` = 1 permanently; `run` toggling has no effect until `rst_n` is low.

Source files
------------

// File: rtl/ctrl_pkg.sv
// ctrl_pkg
// Shared definitions for the multicycle control unit: the controller state
// enumeration, the decoded instruction classes, the opcode map and the
// select encodings driven onto the datapath (extender, ALU op, ALU B source).
package ctrl_pkg;

  typedef enum logic [3:0] {
    IDLE,
    FETCH,
    DECODE,
    EXECR,
    EXECI,
    ALUWB,
    MEMADR,
    MEMREAD,
    MEMWB,
    MEMWRITE,
    BRANCH,
    HALT
  } state_t;

  typedef enum logic [2:0] {
    CLS_REG,
    CLS_IMM,
    CLS_MEM,
    CLS_BRANCH,
    CLS_HALT,
    CLS_ILLEGAL
  } instrClass_t;

  // Opcode map (Instr[31:28])
  localparam logic [3:0] OP_ADD  = 4'b0000;
  localparam logic [3:0] OP_SUB  = 4'b0001;
  localparam logic [3:0] OP_AND  = 4'b0010;
  localparam logic [3:0] OP_OR   = 4'b0011;
  localparam logic [3:0] OP_ADDI = 4'b0100;
  localparam logic [3:0] OP_SUBI = 4'b0101;
  localparam logic [3:0] OP_LDR  = 4'b0110;
  localparam logic [3:0] OP_STR  = 4'b0111;
  localparam logic [3:0] OP_B    = 4'b1000;
  localparam logic [3:0] OP_BEQ  = 4'b1001;
  localparam logic [3:0] OP_HALT = 4'b1111;

  // Immediate extender select
  localparam logic [1:0] IMM_BRANCH = 2'b00;
  localparam logic [1:0] IMM_MEM    = 2'b01;
  localparam logic [1:0] IMM_ALUI   = 2'b10;
  localparam logic [1:0] IMM_REG    = 2'b11;

  // ALU operation
  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;
  localparam logic [1:0] ALU_AND = 2'b10;
  localparam logic [1:0] ALU_OR  = 2'b11;

  // ALU B operand source
  localparam logic [1:0] ALUB_REG  = 2'b00;
  localparam logic [1:0] ALUB_IMM  = 2'b01;
  localparam logic [1:0] ALUB_FOUR = 2'b10;

endpackage

// File: rtl/control_decode.sv
// control_decode
// Purely combinational opcode classifier used by the DECODE state.
// Ports:
//   opcode     in   OPW  instruction opcode
//   instrClass out  3    instruction class (ctrl_pkg::instrClass_t)
//   immSrc     out  2    extender select for this opcode
//   legal      out  1    opcode is defined
module control_decode
  import ctrl_pkg::*;
#(
  parameter int OPW = 4
) (
  input  logic [OPW-1:0] opcode,
  output instrClass_t    instrClass,
  output logic [1:0]     immSrc,
  output logic           legal
);

  always_comb begin
    instrClass = CLS_ILLEGAL;
    immSrc     = IMM_BRANCH;
    legal      = 1'b1;
    case (opcode)
      OPW'(OP_ADD), OPW'(OP_SUB), OPW'(OP_AND), OPW'(OP_OR): begin
        instrClass = CLS_REG;
        immSrc     = IMM_REG;
      end
      OPW'(OP_ADDI), OPW'(OP_SUBI): begin
        instrClass = CLS_IMM;
        immSrc     = IMM_ALUI;
      end
      OPW'(OP_LDR), OPW'(OP_STR): begin
        instrClass = CLS_MEM;
        immSrc     = IMM_MEM;
      end
      OPW'(OP_B), OPW'(OP_BEQ): begin
        instrClass = CLS_BRANCH;
        immSrc     = IMM_BRANCH;
      end
      OPW'(OP_HALT): begin
        instrClass = CLS_HALT;
      end
      default: begin
        legal = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/multicycle_control.sv
// multicycle_control
// Multicycle processor control FSM. Steps each instruction through
// fetch/decode/execute/memory/writeback and owns every datapath strobe.
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   run          leave IDLE and start fetching
//   opcode       opcode from the instruction register
//   zero         ALU zero flag (used in BRANCH)
//   mem_ready    memory handshake completion
//   mem_req, mem_write, adr_src          memory controls
//   ir_write, pc_write, reg_write        register strobes
//   alu_src_b, alu_op, result_src        datapath selects
//   imm_src      extender select, registered in DECODE
//   halted       high in HALT
//   illegal_op   one-cycle pulse on an undefined opcode
module multicycle_control
  import ctrl_pkg::*;
#(
  parameter int OPW = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           run,
  input  logic [OPW-1:0] opcode,
  input  logic           zero,
  input  logic           mem_ready,
  output logic           mem_req,
  output logic           mem_write,
  output logic           adr_src,
  output logic           ir_write,
  output logic           pc_write,
  output logic           reg_write,
  output logic [1:0]     alu_src_b,
  output logic [1:0]     alu_op,
  output logic           result_src,
  output logic [1:0]     imm_src,
  output logic           halted,
  output logic           illegal_op
);

  state_t      state;
  state_t      nextState;
  instrClass_t decClass;
  logic [1:0]  decImm;
  logic        decLegal;

  control_decode #(.OPW(OPW)) uDecode (
    .opcode     (opcode),
    .instrClass (decClass),
    .immSrc     (decImm),
    .legal      (decLegal)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= nextState;
    end
  end

  // The extender select is held in a register so the immediate stays stable
  // for the whole execute/memory phase. HALT and undefined opcodes leave the
  // previous select in place.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      imm_src <= IMM_BRANCH;
    end else if (state == DECODE && decLegal && decClass != CLS_HALT) begin
      imm_src <= decImm;
    end
  end

  always_comb begin
    nextState  = state;
    mem_req    = 1'b0;
    mem_write  = 1'b0;
    adr_src    = 1'b0;
    ir_write   = 1'b0;
    pc_write   = 1'b0;
    reg_write  = 1'b0;
    alu_src_b  = ALUB_REG;
    alu_op     = ALU_ADD;
    result_src = 1'b0;
    halted     = 1'b0;
    illegal_op = 1'b0;

    case (state)
      IDLE: begin
        if (run) nextState = FETCH;
      end

      FETCH: begin
        mem_req = 1'b1;
        // IR load and PC+4 only once the instruction word has arrived.
        if (mem_ready) begin
          ir_write  = 1'b1;
          pc_write  = 1'b1;
          alu_src_b = ALUB_FOUR;
          alu_op    = ALU_ADD;
          nextState = DECODE;
        end
      end

      DECODE: begin
        case (decClass)
          CLS_REG:    nextState = EXECR;
          CLS_IMM:    nextState = EXECI;
          CLS_MEM:    nextState = MEMADR;
          CLS_BRANCH: nextState = BRANCH;
          CLS_HALT:   nextState = HALT;
          default: begin
            illegal_op = 1'b1;
            nextState  = FETCH;
          end
        endcase
      end

      EXECR: begin
        alu_src_b = ALUB_REG;
        alu_op    = opcode[1:0];
        nextState = ALUWB;
      end

      EXECI: begin
        alu_src_b = ALUB_IMM;
        alu_op    = {1'b0, opcode[0]};
        nextState = ALUWB;
      end

      ALUWB: begin
        reg_write  = 1'b1;
        result_src = 1'b0;
        nextState  = FETCH;
      end

      MEMADR: begin
        alu_src_b = ALUB_IMM;
        alu_op    = ALU_ADD;
        // opcode[0] separates STR from LDR
        nextState = opcode[0] ? MEMWRITE : MEMREAD;
      end

      MEMREAD: begin
        mem_req = 1'b1;
        adr_src = 1'b1;
        if (mem_ready) nextState = MEMWB;
      end

      MEMWB: begin
        reg_write  = 1'b1;
        result_src = 1'b1;
        nextState  = FETCH;
      end

      MEMWRITE: begin
        mem_req   = 1'b1;
        mem_write = 1'b1;
        adr_src   = 1'b1;
        if (mem_ready) nextState = FETCH;
      end

      BRANCH: begin
        alu_src_b = ALUB_IMM;
        alu_op    = ALU_ADD;
        // opcode[0] = 0 is the unconditional B; BEQ needs the zero flag.
        pc_write  = ~opcode[0] | zero;
        nextState = FETCH;
      end

      HALT: begin
        halted    = 1'b1;
        nextState = HALT;
      end

      default: begin
        nextState = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_multicycle_control.sv
// Testbench for multicycle_control. Each instruction is expanded into the
// expected per-cycle output sequence from the instruction's rules, with
// randomized memory wait cycles and random noise on ignored inputs.
module tb_multicycle_control;

  logic       clk;
  logic       rst_n;
  logic       run;
  logic [3:0] opcode;
  logic       zero;
  logic       mem_ready;
  logic       mem_req;
  logic       mem_write;
  logic       adr_src;
  logic       ir_write;
  logic       pc_write;
  logic       reg_write;
  logic [1:0] alu_src_b;
  logic [1:0] alu_op;
  logic       result_src;
  logic [1:0] imm_src;
  logic       halted;
  logic       illegal_op;

  int passCount;
  int checkCount;
  logic [1:0] expImm;

  logic [14:0] obs;
  assign obs = {mem_req, mem_write, adr_src, ir_write, pc_write, reg_write,
                alu_src_b, alu_op, result_src, imm_src, halted, illegal_op};

  multicycle_control #(.OPW(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .run        (run),
    .opcode     (opcode),
    .zero       (zero),
    .mem_ready  (mem_ready),
    .mem_req    (mem_req),
    .mem_write  (mem_write),
    .adr_src    (adr_src),
    .ir_write   (ir_write),
    .pc_write   (pc_write),
    .reg_write  (reg_write),
    .alu_src_b  (alu_src_b),
    .alu_op     (alu_op),
    .result_src (result_src),
    .imm_src    (imm_src),
    .halted     (halted),
    .illegal_op (illegal_op)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, passed=%0d total=%0d", passCount, checkCount);
    $fatal(1, "watchdog");
  end

  function automatic logic rb();
    return 1'($urandom_range(0, 1));
  endfunction

  // Expected output vector; imm_src comes from the model's current extender select.
  function automatic logic [14:0] mk(input logic mr, input logic mw, input logic as,
                                     input logic irw, input logic pcw, input logic rw,
                                     input logic [1:0] b, input logic [1:0] op,
                                     input logic rs, input logic h, input logic il);
    return {mr, mw, as, irw, pcw, rw, b, op, rs, expImm, h, il};
  endfunction

  function automatic logic [14:0] allZero();
    return 15'd0;
  endfunction

  task automatic check(input logic [14:0] exp, input string tag);
    checkCount++;
    assert (obs === exp) passCount++;
    else $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
  endtask

  // One clock cycle: entered at a falling edge, drives inputs, checks the
  // outputs mid-low-phase, and returns at the next falling edge.
  task automatic cyc(input logic r, input logic mr, input logic z,
                     input logic [14:0] exp, input string tag);
    run       = r;
    mem_ready = mr;
    zero      = z;
    #2;
    check(exp, tag);
    @(negedge clk);
  endtask

  // Runs one complete instruction from its first FETCH cycle.
  task automatic runInstr(input logic [3:0] op, input int fw, input int mw,
                          input logic z);
    string nm;
    logic  illegal;
    nm = $sformatf("op%b", op);
    opcode  = op;
    illegal = (op >= 4'd10) && (op <= 4'd14);

    for (int i = 0; i < fw; i++)
      cyc(rb(), 1'b0, rb(), mk(1,0,0,0,0,0,2'b00,2'b00,0,0,0), {nm, "_fetchwait"});
    cyc(rb(), 1'b1, rb(), mk(1,0,0,1,1,0,2'b10,2'b00,0,0,0), {nm, "_fetch"});
    cyc(rb(), rb(), rb(), mk(0,0,0,0,0,0,2'b00,2'b00,0,0,illegal), {nm, "_decode"});

    if (op <= 4'd3) begin
      expImm = 2'b11;
      cyc(rb(), rb(), rb(), mk(0,0,0,0,0,0,2'b00,op[1:0],0,0,0), {nm, "_execr"});
      cyc(rb(), rb(), rb(), mk(0,0,0,0,0,1,2'b00,2'b00,0,0,0), {nm, "_aluwb"});
    end else if (op == 4'd4 || op == 4'd5) begin
      expImm = 2'b10;
      cyc(rb(), rb(), rb(), mk(0,0,0,0,0,0,2'b01,(op == 4'd5) ? 2'b01 : 2'b00,0,0,0), {nm, "_execi"});
      cyc(rb(), rb(), rb(), mk(0,0,0,0,0,1,2'b00,2'b00,0,0,0), {nm, "_aluwb"});
    end else if (op == 4'd6) begin
      expImm = 2'b01;
      cyc(rb(), rb(), rb(), mk(0,0,0,0,0,0,2'b01,2'b00,0,0,0), {nm, "_memadr"});
      for (int i = 0; i < mw; i++)
        cyc(rb(), 1'b0, rb(), mk(1,0,1,0,0,0,2'b00,2'b00,0,0,0), {nm, "_readwait"});
      cyc(rb(), 1'b1, rb(), mk(1,0,1,0,0,0,2'b00,2'b00,0,0,0), {nm, "_read"});
      cyc(rb(), rb(), rb(), mk(0,0,0,0,0,1,2'b00,2'b00,1,0,0), {nm, "_memwb"});
    end else if (op == 4'd7) begin
      expImm = 2'b01;
      cyc(rb(), rb(), rb(), mk(0,0,0,0,0,0,2'b01,2'b00,0,0,0), {nm, "_memadr"});
      for (int i = 0; i < mw; i++)
        cyc(rb(), 1'b0, rb(), mk(1,1,1,0,0,0,2'b00,2'b00,0,0,0), {nm, "_writewait"});
      cyc(rb(), 1'b1, rb(), mk(1,1,1,0,0,0,2'b00,2'b00,0,0,0), {nm, "_write"});
    end else if (op == 4'd8 || op == 4'd9) begin
      expImm = 2'b00;
      cyc(rb(), rb(), z, mk(0,0,0,0,(op == 4'd8) || z,0,2'b01,2'b00,0,0,0), {nm, "_branch"});
    end
    // undefined opcodes: back to FETCH, extender select untouched
    // 1111: the caller observes HALT
  endtask

  initial begin
    logic [3:0] rop;
    passCount  = 0;
    checkCount = 0;
    expImm     = 2'b00;
    rst_n      = 1'b0;
    run        = 1'b0;
    opcode     = 4'd0;
    zero       = 1'b0;
    mem_ready  = 1'b0;

    // Reset state
    @(negedge clk);
    cyc(1'b1, 1'b1, 1'b1, allZero(), "reset_hold");
    cyc(1'b0, 1'b1, 1'b0, allZero(), "reset_hold2");
    rst_n = 1'b1;
    cyc(1'b0, 1'b1, 1'b0, allZero(), "idle_norun");
    cyc(1'b0, 1'b0, 1'b1, allZero(), "idle_norun2");
    cyc(1'b1, 1'b0, 1'b0, allZero(), "idle_run");
    // Now in FETCH; runInstr continues from here

    // ADDI with memory ready: 4 cycles
    runInstr(4'd4, 0, 0, 1'b0);
    // LDR with 3 wait cycles in MEMREAD: 8 cycles
    runInstr(4'd6, 0, 3, 1'b0);
    // BEQ not taken, then taken
    runInstr(4'd9, 0, 0, 1'b0);
    runInstr(4'd9, 0, 0, 1'b1);
    // Immediate select to 10, then an undefined opcode must keep it
    runInstr(4'd5, 1, 0, 1'b0);
    runInstr(4'd10, 0, 0, 1'b0);
    runInstr(4'd2, 0, 0, 1'b0);
    runInstr(4'd7, 2, 1, 1'b0);
    runInstr(4'd8, 0, 0, 1'b0);

    // Randomized instruction stream (no HALT)
    for (int n = 0; n < 40; n++) begin
      rop = 4'($urandom_range(0, 14));
      runInstr(rop, int'($urandom_range(0, 2)), int'($urandom_range(0, 3)), rb());
    end

    // Reset while an LDR is waiting in MEMREAD
    opcode = 4'd6;
    cyc(1'b0, 1'b1, 1'b0, mk(1,0,0,1,1,0,2'b10,2'b00,0,0,0), "midldr_fetch");
    cyc(1'b0, 1'b0, 1'b0, mk(0,0,0,0,0,0,2'b00,2'b00,0,0,0), "midldr_decode");
    expImm = 2'b01;
    cyc(1'b0, 1'b0, 1'b0, mk(0,0,0,0,0,0,2'b01,2'b00,0,0,0), "midldr_memadr");
    cyc(1'b0, 1'b0, 1'b0, mk(1,0,1,0,0,0,2'b00,2'b00,0,0,0), "midldr_readwait");
    rst_n  = 1'b0;
    expImm = 2'b00;
    cyc(1'b1, 1'b1, 1'b1, allZero(), "midldr_reset");
    cyc(1'b1, 1'b1, 1'b1, allZero(), "midldr_reset2");
    rst_n = 1'b1;
    cyc(1'b1, 1'b0, 1'b0, allZero(), "restart_idle_run");
    cyc(1'b0, 1'b0, 1'b0, mk(1,0,0,0,0,0,2'b00,2'b00,0,0,0), "restart_fetch");
    runInstr(4'd1, 0, 0, 1'b0);

    // HALT is sticky until reset
    runInstr(4'd15, 0, 0, 1'b0);
    for (int i = 0; i < 6; i++)
      cyc(1'(i % 2), rb(), rb(), mk(0,0,0,0,0,0,2'b00,2'b00,0,1,0), "halt_hold");
    rst_n  = 1'b0;
    expImm = 2'b00;
    cyc(1'b1, 1'b1, 1'b0, allZero(), "halt_reset");
    rst_n = 1'b1;
    cyc(1'b0, 1'b1, 1'b0, allZero(), "halt_idle");
    cyc(1'b1, 1'b1, 1'b0, allZero(), "halt_idle_run");
    runInstr(4'd3, 0, 0, 1'b0);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
